// File: rtl/serial_uart_endpoint_if.sv
// serial_uart_endpoint_if: processor-side byte port of the UART endpoint.
// master = processor (writes/pops), slave = endpoint (data/valid/ready).
interface serial_uart_endpoint_if;
  logic [7:0] cpu_data_in;
  logic       cpu_wren_in;
  logic       cpu_rden_in;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;

  modport master (
    output cpu_data_in, cpu_wren_in, cpu_rden_in,
    input  cpu_data_out, cpu_valid_out, cpu_ready_out
  );

  modport slave (
    input  cpu_data_in, cpu_wren_in, cpu_rden_in,
    output cpu_data_out, cpu_valid_out, cpu_ready_out
  );
endinterface

// File: rtl/serial_uart_endpoint.sv
// serial_uart_endpoint: TX/RX FIFOs + 8N1 UART between processor and pins.
// Ports: clock, reset (sync, low), cpu (slave), uart_rx_in/uart_tx_out, sticky flags.
module serial_uart_endpoint #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_LOG2    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_uart_endpoint_if.slave cpu,
  input  logic                  uart_rx_in,
  output logic                  uart_tx_out,
  output logic                  rx_overflow_out,
  output logic                  rx_frame_err_out
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int PW    = FIFO_LOG2;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL     = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr, tx_rd;
  logic [PW:0]   tx_count;
  logic          tx_push, tx_pop;

  assign cpu.cpu_ready_out = (tx_count != FULL);
  assign tx_push = cpu.cpu_wren_in && (tx_count != FULL || tx_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      tx_count <= tx_count + (PW+1)'(tx_push)
                           - (PW+1)'(tx_pop);
    end
  end

  always_ff @(posedge clock)
    if (tx_push) tx_mem[tx_wr] <= cpu.cpu_data_in;

  // RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr, rx_rd;
  logic [PW:0]   rx_count;
  logic          rx_push, rx_pop, rx_store;

  assign rx_pop  = cpu.cpu_rden_in && (rx_count != '0);
  assign rx_push = rx_store && (rx_count != FULL || rx_pop);
  assign cpu.cpu_valid_out = (rx_count != '0);
  assign cpu.cpu_data_out  =
    (rx_count != '0) ? rx_mem[rx_rd] : 8'h00;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      rx_count <= rx_count + (PW+1)'(rx_push)
                           - (PW+1)'(rx_pop);
    end
  end

  // TX FSM
  uart_state_e   tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic          tx_line, tx_line_d;

  assign uart_tx_out = tx_line;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + CW'(1);
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_line_d  = tx_line;
    tx_pop     = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd];
          tx_state_d = START;
          tx_line_d  = 1'b0;
        end
      end
      START: if (tx_cnt == BIT_END) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = DATA;
        tx_line_d  = tx_shift[0];
      end
      DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift >> 1;
        if (tx_bit == 3'd7) begin
          tx_state_d = STOP;
          tx_line_d  = 1'b1;
        end else begin
          tx_bit_d  = tx_bit + 3'd1;
          tx_line_d = tx_shift[1];
        end
      end
      STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        // Back-to-back frames: reload straight into START.
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd];
          tx_state_d = START;
          tx_line_d  = 1'b0;
        end else begin
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // RX synchronizer and FSM
  logic rx_meta, rx_sync;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_in;
      rx_sync <= rx_meta;
    end
  end

  uart_state_e   rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic          err_set, ovf_set;

  assign ovf_set = rx_store && rx_count == FULL && !rx_pop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state         <= IDLE;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_overflow_out  <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      if (ovf_set) rx_overflow_out  <= 1'b1;
      if (err_set) rx_frame_err_out <= 1'b1;
    end
  end

  always_ff @(posedge clock)
    if (rx_push) rx_mem[rx_wr] <= rx_shift;

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + CW'(1);
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_store   = 1'b0;
    err_set    = 1'b0;
    unique case (rx_state)
      IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync) rx_state_d = START;
      end
      // Half-bit re-check filters short glitches
      // and aligns later samples to mid-bit.
      START: if (rx_cnt == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync ? IDLE : DATA;
      end
      DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_d = STOP;
        else rx_bit_d = rx_bit + 3'd1;
      end
      STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_d   = '0;
        rx_state_d = IDLE;
        rx_store   = rx_sync;
        err_set    = !rx_sync;
      end
      default: rx_state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_uart_endpoint.sv
// tb_serial_uart_endpoint: directed bench for serial_uart_endpoint.
// CLKS_PER_BIT=4; drives on negedge, samples on negedge.
module tb_serial_uart_endpoint;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_rx_in = 1'b1;
  logic uart_tx_out;
  logic rx_overflow_out;
  logic rx_frame_err_out;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  serial_uart_endpoint_if cpu_if ();

  serial_uart_endpoint #(
    .CLKS_PER_BIT(CPB),
    .FIFO_LOG2(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu(cpu_if),
    .uart_rx_in(uart_rx_in),
    .uart_tx_out(uart_tx_out),
    .rx_overflow_out(rx_overflow_out),
    .rx_frame_err_out(rx_frame_err_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_if.cpu_wren_in = 1'b0;
    cpu_if.cpu_rden_in = 1'b0;
    cpu_if.cpu_data_in = 8'h00;
    uart_rx_in = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic uart_send(input logic [7:0] b,
                           input logic stop);
    uart_rx_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int j = 0; j < 8; j++) begin
      uart_rx_in = b[j];
      repeat (CPB) @(negedge clock);
    end
    uart_rx_in = stop;
    repeat (CPB) @(negedge clock);
    uart_rx_in = 1'b1;
  endtask

  // Decode one TX frame; returns the cycle its start bit was first seen.
  task automatic tx_capture(output logic [7:0] b,
                            output int t0);
    logic found = 1'b0;
    b = 8'h00;
    t0 = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (uart_tx_out == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      chk("tx_start_timeout", 0, 1);
    end else begin
      t0 = cyc;
      repeat (CPB + 1) @(negedge clock);
      b[0] = uart_tx_out;
      for (int j = 1; j < 8; j++) begin
        repeat (CPB) @(negedge clock);
        b[j] = uart_tx_out;
      end
      repeat (CPB) @(negedge clock);
      chk("tx_stop_bit", uart_tx_out, 1);
      repeat (2) @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b;
    logic [7:0] got_b;
    int t0, t_prev, lows;

    // Reset state
    do_reset();
    chk("rst_tx", uart_tx_out, 1);
    chk("rst_valid", cpu_if.cpu_valid_out, 0);
    chk("rst_ready", cpu_if.cpu_ready_out, 1);
    chk("rst_data", cpu_if.cpu_data_out, 0);
    chk("rst_ovf", rx_overflow_out, 0);
    chk("rst_ferr", rx_frame_err_out, 0);

    // Single TX byte, exact bit timing
    exp_b = 8'h55;
    cpu_if.cpu_data_in = exp_b;
    cpu_if.cpu_wren_in = 1'b1;
    @(negedge clock);
    cpu_if.cpu_wren_in = 1'b0;
    chk("tx55_k0", uart_tx_out, 1);
    for (int k = 1; k <= 40; k++) begin
      logic e;
      @(negedge clock);
      if (k <= 4) e = 1'b0;
      else if (k <= 36) e = exp_b[(k - 5) / 4];
      else e = 1'b1;
      chk($sformatf("tx55_k%0d", k), uart_tx_out, e);
      chk("tx55_ready", cpu_if.cpu_ready_out, 1);
    end

    // 17 back-to-back bytes, then a dropped 18th
    do_reset();
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          chk($sformatf("wr_ready_%0d", i),
              cpu_if.cpu_ready_out, 1);
          cpu_if.cpu_data_in = 8'(i);
          cpu_if.cpu_wren_in = 1'b1;
          @(negedge clock);
        end
        chk("ready_full", cpu_if.cpu_ready_out, 0);
        cpu_if.cpu_data_in = 8'hEE;
        @(negedge clock);
        cpu_if.cpu_wren_in = 1'b0;
        chk("ready_still_full", cpu_if.cpu_ready_out, 0);
      end
      begin
        t_prev = 0;
        for (int i = 0; i < 17; i++) begin
          tx_capture(got_b, t0);
          chk($sformatf("tx_byte_%0d", i), got_b, 8'(i));
          if (i > 0)
            chk($sformatf("tx_gap_%0d", i),
                t0 - t_prev, 40);
          t_prev = t0;
        end
      end
    join
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (uart_tx_out == 1'b0) lows++;
    end
    chk("tx_drop_no_frame", lows, 0);
    chk("tx_drain_ready", cpu_if.cpu_ready_out, 1);

    // RX one frame and pop
    do_reset();
    uart_send(8'hA3, 1'b1);
    repeat (4) @(negedge clock);
    chk("rx_a3_valid", cpu_if.cpu_valid_out, 1);
    chk("rx_a3_data", cpu_if.cpu_data_out, 8'hA3);
    chk("rx_a3_ferr", rx_frame_err_out, 0);
    cpu_if.cpu_rden_in = 1'b1;
    @(negedge clock);
    cpu_if.cpu_rden_in = 1'b0;
    chk("rx_pop_valid", cpu_if.cpu_valid_out, 0);
    chk("rx_pop_data", cpu_if.cpu_data_out, 0);

    // Glitch, then framing error
    uart_rx_in = 1'b0;
    @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (12) @(negedge clock);
    chk("glitch_valid", cpu_if.cpu_valid_out, 0);
    chk("glitch_ferr", rx_frame_err_out, 0);
    chk("glitch_ovf", rx_overflow_out, 0);
    uart_send(8'h3C, 1'b0);
    repeat (8) @(negedge clock);
    chk("ferr_set", rx_frame_err_out, 1);
    chk("ferr_valid", cpu_if.cpu_valid_out, 0);

    // RX overflow: 17 frames, no pops
    do_reset();
    chk("ovf_rst_ferr", rx_frame_err_out, 0);
    for (int i = 0; i < 17; i++) begin
      uart_send(8'(i * 7 + 3), 1'b1);
      if (i == 15) chk("ovf_pre", rx_overflow_out, 0);
    end
    repeat (4) @(negedge clock);
    chk("ovf_set", rx_overflow_out, 1);
    chk("ovf_ferr", rx_frame_err_out, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_valid_%0d", i),
          cpu_if.cpu_valid_out, 1);
      chk($sformatf("ovf_data_%0d", i),
          cpu_if.cpu_data_out, 8'(i * 7 + 3));
      cpu_if.cpu_rden_in = 1'b1;
      @(negedge clock);
    end
    cpu_if.cpu_rden_in = 1'b0;
    chk("ovf_empty", cpu_if.cpu_valid_out, 0);

    // Reset in the middle of a TX frame
    do_reset();
    cpu_if.cpu_wren_in = 1'b1;
    cpu_if.cpu_data_in = 8'h81;
    @(negedge clock);
    cpu_if.cpu_data_in = 8'h42;
    @(negedge clock);
    cpu_if.cpu_data_in = 8'h24;
    @(negedge clock);
    cpu_if.cpu_wren_in = 1'b0;
    repeat (10) @(negedge clock);
    chk("mid_in_data_bit", uart_tx_out, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_tx", uart_tx_out, 1);
    chk("mid_rst_ready", cpu_if.cpu_ready_out, 1);
    reset = 1'b1;
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (uart_tx_out == 1'b0) lows++;
    end
    chk("mid_rst_no_frame", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
